ofdm_rx_ctrl: RTL and testbench
===============================

# ofdm_rx_ctrl

Receive-chain sequencer for the OFDM RX path. Owns the datapath's `sys_init`, watches the incoming sample stream and the symbol-start markers from timing sync, and tracks acquire/lock/drain per frame. Raises lost-sync and frame-done events. Sits between system control and the `tbd_ofdm_rx` datapath, and re-initialises the datapath when it loses synchronisation.

## Interface
- `symbol_length_g`, 160: samples per OFDM symbol, cyclic prefix included.
- `tolerance_g`, 2: allowed ± sample deviation of the symbol-start spacing.
- `symbols_per_frame_g`, 10: accepted symbol starts that complete a frame.
- `search_timeout_g`, 4096: samples allowed in SEARCH without a symbol start.
- `init_cycles_g`, 2: cycles `dp_init` is held high (minimum 1).
- `drain_cycles_g`, 256: quiet cycles on `rcv_data_valid` that end DRAIN.
- `sys_clk`, in, 1: system clock; the only clock.
- `sys_rst`, in, 1: synchronous, active-high reset.
- `ctrl_enable`, in, 1: level; 0 aborts to IDLE.
- `ctrl_restart`, in, 1: pulse; forces re-initialisation.
- `rx_data_valid`, in, 1: one pulse per input sample.
- `symbol_start`, in, 1: single-cycle pulse from timing sync.
- `rcv_data_valid`, in, 1: demapped-bit strobe from the datapath.
- `dp_init`, out, 1: drives the datapath's `sys_init`.
- `state_o`, out, 3: current state encoding.
- `locked`, out, 1: high while in LOCKED.
- `symbol_cnt`, out, 8: symbols accepted in the current frame.
- `sync_timeout`, out, 1: one-cycle pulse when SEARCH times out.
- `lost_sync`, out, 1: one-cycle pulse when LOCKED aborts.
- `frame_done`, out, 1: one-cycle pulse at the end of DRAIN.
- `frame_count`, out, 16: statistics output.
- `lost_count`, out, 16: statistics output.

## Operation
- States: IDLE, INIT, SEARCH, LOCKED, DRAIN.
- Priority, highest first:
  1. `sys_rst`
  2. `!ctrl_enable` → IDLE
  3. `ctrl_restart` → INIT (from any state except IDLE)
  4. normal transitions
- IDLE: `ctrl_enable`=1 → INIT.
- INIT: `dp_init`=1 for exactly `init_cycles_g` cycles, then → SEARCH. The sample counter `cnt` and `symbol_cnt` are cleared.
- SEARCH: `cnt` increments on each `rx_data_valid`.
  - `symbol_start` → LOCKED, `symbol_cnt`=1, `cnt`=0.
  - `cnt` reaching `search_timeout_g` → pulse `sync_timeout`, → INIT.
  - `symbol_start` and the timeout in the same cycle: the start wins.
- LOCKED: `cnt` counts samples since the last accepted start.
  - `symbol_start` with `symbol_length_g`−`tolerance_g` ≤ `cnt` ≤ `symbol_length_g`+`tolerance_g`: accepted, `symbol_cnt`++, `cnt`=0.
  - `symbol_start` outside that window: pulse `lost_sync`, → INIT.
  - `cnt` reaching `symbol_length_g`+`tolerance_g`+1: pulse `lost_sync`, → INIT.
  - The accept that brings `symbol_cnt` to `symbols_per_frame_g` → DRAIN.
- `rx_data_valid` coinciding with an accepted start: that sample is sample 0 and is not counted.
- DRAIN: a quiet counter is cleared on each `rcv_data_valid` and otherwise increments.
  - Reaching `drain_cycles_g` → pulse `frame_done`, → INIT (automatic next-frame acquisition).
  - `symbol_start` pulses in DRAIN are ignored.
- Counter widths: `$clog2` of the largest compare value +1; no wrap is reachable.

## Timing
- All outputs are registered and update one cycle after the triggering input edge.
- `dp_init` rises in the first INIT cycle and the transition into SEARCH follows on the cycle after its last high cycle.
- Reset values:
  - `state_o`=IDLE
  - `dp_init`=0
  - `locked`=0
  - `symbol_cnt`=0
  - all pulse outputs =0
  - all counters =0
- Reset or `!ctrl_enable` mid-frame: immediate IDLE next cycle. `dp_init` drops, counters clear, no `lost_sync` pulse.
- `ctrl_restart` while already in INIT: the INIT hold count restarts.
- Event pulses are never wider than one cycle, and at most one event pulse fires per cycle.

## Configuration
- `OFDM_RX_CTRL_STATS_EN` defined:
  - `frame_count` increments on `frame_done`.
  - `lost_count` increments on `lost_sync` or `sync_timeout`.
  - Both are 16-bit, saturate at 0xFFFF, and clear only on `sys_rst`.
- Undefined: both outputs are tied to 0 and no counter logic is built.

## Structure
- Shared package `ofdm_rx_pkg` holds:
  - `rx_ctrl_state_t` enum: IDLE=0, INIT=1, SEARCH=2, LOCKED=3, DRAIN=4.
  - A `stat_width_c`=16 constant.
- Sub-module `ofdm_rx_sym_window`:
  - Contains the sample counter and the window compare.
  - Inputs: clear, count-enable.
  - Outputs: `in_window`, `overrun`, `search_expired`.
- The top level holds the FSM and the event/statistics registers.

## Test plan
- Reset, `ctrl_enable`=1: `dp_init` high for exactly 2 cycles, then `state_o`=SEARCH; all outputs 0 before `ctrl_enable`.
- Samples every 24 cycles, `symbol_start` on sample 0 and then every 160 samples × 10: `symbol_cnt` 1→10, `locked`=1. After 256 cycles with `rcv_data_valid` quiet: `frame_done` pulse and re-INIT. With STATS, `frame_count`=1.
- Starts at spacings of 158 then 163 while LOCKED: the first is accepted, the second pulses `lost_sync`; `dp_init` reasserts, `lost_count`=1.
- No `symbol_start` for 4096 samples in SEARCH: `sync_timeout` pulse at sample 4096, → INIT.
- In SEARCH, `symbol_start` in the same cycle the count reaches 4096: → LOCKED, no `sync_timeout`.
- `ctrl_enable`=0 during LOCKED with `symbol_cnt`=5: IDLE next cycle, `symbol_cnt`=0, no `lost_sync`. Same abort issued together with `ctrl_restart`: IDLE wins.

Source files
------------

// File: rtl/ofdm_rx_pkg.sv
// ofdm_rx_pkg: shared state encoding, statistics width and counter sizing helper
package ofdm_rx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      INIT   = 3'd1,
      SEARCH = 3'd2,
      LOCKED = 3'd3,
      DRAIN  = 3'd4
   } rx_ctrl_state_t;

   localparam int stat_width_c = 16;

   // one spare bit above the largest value a counter is compared against
   function automatic int cnt_width(input int max_val);
      return $clog2(max_val) + 1;
   endfunction

endpackage

// File: rtl/ofdm_rx_sym_window.sv
// ofdm_rx_sym_window: sample counter with symbol-spacing window and search-timeout compares
module ofdm_rx_sym_window
   import ofdm_rx_pkg::*;
#(
   parameter int symbol_length_g  = 160,
   parameter int tolerance_g      = 2,
   parameter int search_timeout_g = 4096
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic clear,
   input  logic count_en,
   output logic in_window,
   output logic overrun,
   output logic search_expired
);

   localparam int late_c = symbol_length_g + tolerance_g + 1;
   localparam int cw_c   = cnt_width(search_timeout_g > late_c ? search_timeout_g : late_c);

   logic [cw_c-1:0] cnt;
   logic [cw_c-1:0] cnt_inc;

   // compares include the sample arriving this cycle, so a start that
   // coincides with a sample sees the full spacing
   assign cnt_inc        = cnt + cw_c'(count_en);
   assign in_window      = cnt_inc >= cw_c'(symbol_length_g - tolerance_g) &&
                           cnt_inc <= cw_c'(symbol_length_g + tolerance_g);
   assign overrun        = cnt_inc == cw_c'(late_c);
   assign search_expired = cnt_inc == cw_c'(search_timeout_g);

   // clear wins over count, so a sample on an accepted start becomes sample 0
   always_ff @(posedge sys_clk) begin
      if (sys_rst || clear) cnt <= '0;
      else cnt <= cnt_inc;
   end

endmodule

// File: rtl/ofdm_rx_ctrl.sv
// ofdm_rx_ctrl: OFDM RX sequencer (init/search/lock/drain); OFDM_RX_CTRL_STATS_EN builds frame/lost counters
module ofdm_rx_ctrl
   import ofdm_rx_pkg::*;
#(
   parameter int symbol_length_g     = 160,
   parameter int tolerance_g         = 2,
   parameter int symbols_per_frame_g = 10,
   parameter int search_timeout_g    = 4096,
   parameter int init_cycles_g       = 2,
   parameter int drain_cycles_g      = 256
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst,
   input  logic                    ctrl_enable,
   input  logic                    ctrl_restart,
   input  logic                    rx_data_valid,
   input  logic                    symbol_start,
   input  logic                    rcv_data_valid,
   output logic                    dp_init,
   output logic [2:0]              state_o,
   output logic                    locked,
   output logic [7:0]              symbol_cnt,
   output logic                    sync_timeout,
   output logic                    lost_sync,
   output logic                    frame_done,
   output logic [stat_width_c-1:0] frame_count,
   output logic [stat_width_c-1:0] lost_count
);

   localparam int iw_c = cnt_width(init_cycles_g);
   localparam int qw_c = cnt_width(drain_cycles_g);

   rx_ctrl_state_t  state;
   logic [iw_c-1:0] init_cnt;
   logic [qw_c-1:0] quiet_cnt;
   logic            win_clr;
   logic            in_window;
   logic            overrun;
   logic            search_expired;

   assign state_o = state;
   assign win_clr = !(state == SEARCH || state == LOCKED) || symbol_start;

   ofdm_rx_sym_window #(
      .symbol_length_g (symbol_length_g),
      .tolerance_g     (tolerance_g),
      .search_timeout_g(search_timeout_g)
   ) u_win (
      .sys_clk       (sys_clk),
      .sys_rst       (sys_rst),
      .clear         (win_clr),
      .count_en      (rx_data_valid),
      .in_window     (in_window),
      .overrun       (overrun),
      .search_expired(search_expired)
   );

   // sequencer with registered outputs; every path into INIT reloads the hold count
   always_ff @(posedge sys_clk) begin
      sync_timeout <= 1'b0;
      lost_sync    <= 1'b0;
      frame_done   <= 1'b0;
      if (sys_rst || !ctrl_enable) begin
         state      <= IDLE;
         dp_init    <= 1'b0;
         locked     <= 1'b0;
         symbol_cnt <= '0;
         init_cnt   <= '0;
         quiet_cnt  <= '0;
      end else if (ctrl_restart && state != IDLE) begin
         state      <= INIT;
         dp_init    <= 1'b1;
         locked     <= 1'b0;
         symbol_cnt <= '0;
         init_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               state    <= INIT;
               dp_init  <= 1'b1;
               init_cnt <= '0;
            end
            INIT: begin
               if (init_cnt == iw_c'(init_cycles_g - 1)) begin
                  state   <= SEARCH;
                  dp_init <= 1'b0;
               end else begin
                  init_cnt <= init_cnt + iw_c'(1);
               end
            end
            SEARCH: begin
               if (symbol_start) begin
                  state      <= LOCKED;
                  locked     <= 1'b1;
                  symbol_cnt <= 8'd1;
               end else if (search_expired) begin
                  sync_timeout <= 1'b1;
                  state        <= INIT;
                  dp_init      <= 1'b1;
                  init_cnt     <= '0;
                  symbol_cnt   <= '0;
               end
            end
            LOCKED: begin
               if (symbol_start && in_window) begin
                  symbol_cnt <= symbol_cnt + 8'd1;
                  if (symbol_cnt + 8'd1 == 8'(symbols_per_frame_g)) begin
                     state     <= DRAIN;
                     locked    <= 1'b0;
                     quiet_cnt <= '0;
                  end
               end else if (symbol_start || overrun) begin
                  lost_sync  <= 1'b1;
                  state      <= INIT;
                  dp_init    <= 1'b1;
                  locked     <= 1'b0;
                  init_cnt   <= '0;
                  symbol_cnt <= '0;
               end
            end
            DRAIN: begin
               if (rcv_data_valid) begin
                  quiet_cnt <= '0;
               end else if (quiet_cnt + qw_c'(1) == qw_c'(drain_cycles_g)) begin
                  frame_done <= 1'b1;
                  state      <= INIT;
                  dp_init    <= 1'b1;
                  init_cnt   <= '0;
                  symbol_cnt <= '0;
               end else begin
                  quiet_cnt <= quiet_cnt + qw_c'(1);
               end
            end
            default: begin
               state   <= IDLE;
               dp_init <= 1'b0;
               locked  <= 1'b0;
            end
         endcase
      end
   end

`ifdef OFDM_RX_CTRL_STATS_EN
   // saturating event counters, cleared only by reset
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         frame_count <= '0;
         lost_count  <= '0;
      end else begin
         if (frame_done && frame_count != '1) frame_count <= frame_count + stat_width_c'(1);
         if ((lost_sync || sync_timeout) && lost_count != '1) lost_count <= lost_count + stat_width_c'(1);
      end
   end
`else
   assign frame_count = '0;
   assign lost_count  = '0;
`endif

endmodule

// File: tb/tb_ofdm_rx_ctrl.sv
// tb_ofdm_rx_ctrl: directed bench for the OFDM RX sequencer
module tb_ofdm_rx_ctrl;
   import ofdm_rx_pkg::*;

`ifdef OFDM_RX_CTRL_STATS_EN
   localparam int stats_c = 1;
`else
   localparam int stats_c = 0;
`endif

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        ctrl_enable = 1'b0;
   logic        ctrl_restart = 1'b0;
   logic        rx_data_valid = 1'b0;
   logic        symbol_start = 1'b0;
   logic        rcv_data_valid = 1'b0;
   logic        dp_init;
   logic [2:0]  state_o;
   logic        locked;
   logic [7:0]  symbol_cnt;
   logic        sync_timeout;
   logic        lost_sync;
   logic        frame_done;
   logic [15:0] frame_count;
   logic [15:0] lost_count;

   int total = 0;
   int bad = 0;
   int n_lost = 0;
   int n_to = 0;
   int n_done = 0;
   int multi = 0;
   logic [2:0] prev_ev = 3'b000;

   ofdm_rx_ctrl dut (
      .sys_clk       (sys_clk),
      .sys_rst       (sys_rst),
      .ctrl_enable   (ctrl_enable),
      .ctrl_restart  (ctrl_restart),
      .rx_data_valid (rx_data_valid),
      .symbol_start  (symbol_start),
      .rcv_data_valid(rcv_data_valid),
      .dp_init       (dp_init),
      .state_o       (state_o),
      .locked        (locked),
      .symbol_cnt    (symbol_cnt),
      .sync_timeout  (sync_timeout),
      .lost_sync     (lost_sync),
      .frame_done    (frame_done),
      .frame_count   (frame_count),
      .lost_count    (lost_count)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic tick();
      logic [2:0] ev;
      @(posedge sys_clk);
      #1;
      ev = {sync_timeout, lost_sync, frame_done};
      if (sync_timeout) n_to++;
      if (lost_sync) n_lost++;
      if (frame_done) n_done++;
      if ($countones(ev) > 1 || (ev & prev_ev) != 3'b000) multi++;
      prev_ev = ev;
   endtask

   task automatic samp(input logic st);
      rx_data_valid = 1'b1;
      symbol_start  = st;
      tick();
      rx_data_valid = 1'b0;
      symbol_start  = 1'b0;
   endtask

   task automatic samp_gap(input logic st, input int gap);
      samp(st);
      repeat (gap - 1) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

   initial begin
      repeat (3) tick();
      sys_rst = 1'b0;
      repeat (2) tick();
      chk("rst_state", 32'(state_o), 32'(IDLE));
      chk("rst_dp_init", 32'(dp_init), 0);
      chk("rst_locked", 32'(locked), 0);
      chk("rst_symcnt", 32'(symbol_cnt), 0);
      chk("rst_events", 32'({sync_timeout, lost_sync, frame_done}), 0);
      chk("rst_stats", {frame_count, lost_count}, 0);

      ctrl_enable = 1'b1;
      tick();
      chk("init1_state", 32'(state_o), 32'(INIT));
      chk("init1_dp", 32'(dp_init), 1);
      tick();
      chk("init2_dp", 32'(dp_init), 1);
      tick();
      chk("search_state", 32'(state_o), 32'(SEARCH));
      chk("search_dp", 32'(dp_init), 0);

      samp_gap(1'b1, 24);
      chk("lock_state", 32'(state_o), 32'(LOCKED));
      chk("lock_symcnt", 32'(symbol_cnt), 1);
      chk("lock_locked", 32'(locked), 1);
      for (int k = 2; k <= 10; k++) begin
         repeat (159) samp_gap(1'b0, 24);
         samp_gap(1'b1, 24);
         chk("frame_symcnt", 32'(symbol_cnt), 32'(k));
         chk("frame_state", 32'(state_o), k < 10 ? 32'(LOCKED) : 32'(DRAIN));
         chk("frame_locked", 32'(locked), k < 10 ? 1 : 0);
      end

      rcv_data_valid = 1'b1;
      tick();
      rcv_data_valid = 1'b0;
      repeat (100) tick();
      symbol_start = 1'b1;
      tick();
      symbol_start = 1'b0;
      chk("drain_ignore_start", 32'(state_o), 32'(DRAIN));
      repeat (154) tick();
      chk("drain_255_done", 32'(frame_done), 0);
      chk("drain_255_state", 32'(state_o), 32'(DRAIN));
      tick();
      chk("drain_done", 32'(frame_done), 1);
      chk("drain_reinit", 32'(state_o), 32'(INIT));
      chk("drain_dp", 32'(dp_init), 1);
      tick();
      chk("done_width", 32'(frame_done), 0);
      chk("frame_count", 32'(frame_count), 32'(stats_c));
      tick();
      chk("done_search", 32'(state_o), 32'(SEARCH));

      samp(1'b1);
      repeat (157) samp(1'b0);
      samp(1'b1);
      chk("sp158_symcnt", 32'(symbol_cnt), 2);
      chk("sp158_state", 32'(state_o), 32'(LOCKED));
      repeat (162) samp(1'b0);
      chk("sp162_state", 32'(state_o), 32'(LOCKED));
      samp(1'b1);
      chk("sp163_lost", 32'(lost_sync), 1);
      chk("sp163_state", 32'(state_o), 32'(INIT));
      chk("sp163_dp", 32'(dp_init), 1);
      chk("sp163_locked", 32'(locked), 0);
      chk("sp163_symcnt", 32'(symbol_cnt), 0);
      tick();
      chk("lost_width", 32'(lost_sync), 0);
      chk("lost_count1", 32'(lost_count), 32'(stats_c));
      tick();
      chk("lost_search", 32'(state_o), 32'(SEARCH));

      repeat (4095) samp(1'b0);
      chk("to4095_pulse", 32'(sync_timeout), 0);
      chk("to4095_state", 32'(state_o), 32'(SEARCH));
      samp(1'b0);
      chk("to4096_pulse", 32'(sync_timeout), 1);
      chk("to4096_state", 32'(state_o), 32'(INIT));
      tick();
      chk("to_width", 32'(sync_timeout), 0);
      chk("lost_count2", 32'(lost_count), 32'(2 * stats_c));
      tick();
      chk("to_search", 32'(state_o), 32'(SEARCH));

      repeat (4095) samp(1'b0);
      samp(1'b1);
      chk("tie_state", 32'(state_o), 32'(LOCKED));
      chk("tie_pulse", 32'(sync_timeout), 0);
      chk("tie_symcnt", 32'(symbol_cnt), 1);
      repeat (4) begin
         repeat (159) samp(1'b0);
         samp(1'b1);
      end
      chk("abort_pre_symcnt", 32'(symbol_cnt), 5);
      ctrl_enable = 1'b0;
      tick();
      chk("abort_state", 32'(state_o), 32'(IDLE));
      chk("abort_symcnt", 32'(symbol_cnt), 0);
      chk("abort_locked", 32'(locked), 0);
      chk("abort_dp", 32'(dp_init), 0);
      chk("abort_lost", 32'(lost_sync), 0);

      ctrl_enable = 1'b1;
      tick();
      chk("reen_state", 32'(state_o), 32'(INIT));
      repeat (2) tick();
      chk("reen_search", 32'(state_o), 32'(SEARCH));
      samp(1'b1);
      repeat (4) begin
         repeat (159) samp(1'b0);
         samp(1'b1);
      end
      chk("abort2_pre_symcnt", 32'(symbol_cnt), 5);
      ctrl_enable  = 1'b0;
      ctrl_restart = 1'b1;
      tick();
      ctrl_restart = 1'b0;
      chk("abort2_state", 32'(state_o), 32'(IDLE));
      chk("abort2_symcnt", 32'(symbol_cnt), 0);
      chk("abort2_lost", 32'(lost_sync), 0);

      ctrl_enable = 1'b1;
      repeat (2) tick();
      ctrl_restart = 1'b1;
      tick();
      ctrl_restart = 1'b0;
      chk("rinit_state", 32'(state_o), 32'(INIT));
      chk("rinit_dp", 32'(dp_init), 1);
      tick();
      chk("rinit_hold", 32'(state_o), 32'(INIT));
      tick();
      chk("rinit_search", 32'(state_o), 32'(SEARCH));
      chk("rinit_dp_low", 32'(dp_init), 0);

      samp(1'b1);
      chk("rlock_state", 32'(state_o), 32'(LOCKED));
      ctrl_restart = 1'b1;
      tick();
      ctrl_restart = 1'b0;
      chk("rlock_init", 32'(state_o), 32'(INIT));
      chk("rlock_symcnt", 32'(symbol_cnt), 0);
      chk("rlock_locked", 32'(locked), 0);
      chk("rlock_lost", 32'(lost_sync), 0);

      chk("n_lost", 32'(n_lost), 1);
      chk("n_timeout", 32'(n_to), 1);
      chk("n_done", 32'(n_done), 1);
      chk("pulse_rules", 32'(multi), 0);
      chk("final_frame_count", 32'(frame_count), 32'(stats_c));
      chk("final_lost_count", 32'(lost_count), 32'(2 * stats_c));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
